// File: rtl/rx_pkg.sv
// Shared constants and state encoding for the oversampling serial blocks.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package rx_pkg;

    // Default system clock and serial bit rate.
    localparam int CLOCK_DEFAULT = 50_000_000;
    localparam int RATE_DEFAULT  = 9600;

    // Ticks per serial bit; mid-bit sampling is at tick OVERSAMPLE/2.
    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Clocks per oversample tick (integer division, truncating).
    function automatic int calc_div(input int clock, input int rate, input int oversample);
        return clock / (rate * oversample);
    endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Free-running oversample tick generator: one-clk tick every CLOCK/(RATE*OVERSAMPLE) clks.
// Latency: tick is decoded from the divider register, first tick DIV clks after reset release.
// Backpressure: none; runs continuously.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset, clears the divider
//   tick  - one-clk pulse at the oversample rate
module baud_tick #(
    parameter int CLOCK      = rx_pkg::CLOCK_DEFAULT,
    parameter int RATE       = rx_pkg::RATE_DEFAULT,
    parameter int OVERSAMPLE = rx_pkg::OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = rx_pkg::calc_div(CLOCK, RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rx.sv
// 8N1 serial receiver, 16x oversampled, mid-bit sampling, LSB first.
// Latency: rch/valid (or ferr) update one clk after the mid-stop-bit sample.
// Backpressure: none; valid/ferr are single-cycle pulses, rch holds the last good byte.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   rxd   - asynchronous serial input, idle high
//   rch   - last correctly framed byte
//   valid - one-clk pulse when rch is updated
//   ferr  - one-clk pulse when the stop bit samples low
//   busy  - high while a frame is in progress
module rx
    import rx_pkg::*;
#(
    parameter int CLOCK = CLOCK_DEFAULT,
    parameter int RATE  = RATE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rch,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    logic       tick;

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [2:0] settle_q;

    state_e     state_q;
    state_e     state_d;

    logic [3:0] tcnt_q;
    logic [3:0] tcnt_d;
    logic [2:0] bidx_q;
    logic [2:0] bidx_d;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [7:0] rch_q;
    logic [7:0] rch_d;
    logic       valid_q;
    logic       valid_d;
    logic       ferr_q;
    logic       ferr_d;

    logic       line;
    logic       fall;
    logic       mid_hit;
    logic       end_hit;

    baud_tick #(
        .CLOCK      (CLOCK),
        .RATE       (RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Synchronizer plus one history flop for edge detection. The synchronizer
    // resets to 1, so its first two post-reset outputs are not the real line;
    // settle_q holds off edge detection until prev_q also carries a real sample,
    // so a line already low at reset release cannot fake a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= '0;
        end else begin
            sync1_q  <= rxd;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[1:0], 1'b1};
        end
    end

    assign line    = sync2_q;
    assign fall    = settle_q[2] & prev_q & ~sync2_q;
    assign mid_hit = tick && (tcnt_q == MID_TICK);
    assign end_hit = tick && (tcnt_q == LAST_TICK);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_hit) begin
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_hit && (bidx_q == 3'd7)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (end_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-state logic. The tick counter runs on every tick
    // and wraps at 16; it is re-zeroed at the falling edge and again at
    // mid-start so every later 16th tick lands mid-bit.
    always_comb begin
        tcnt_d  = tcnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        rch_d   = rch_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    tcnt_d = '0;
                end
            end
            ST_START: begin
                if (mid_hit) begin
                    tcnt_d = '0;
                    bidx_d = '0;
                end
            end
            ST_DATA: begin
                if (end_hit) begin
                    shreg_d = {line, shreg_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (end_hit) begin
                    if (line) begin
                        rch_d   = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            rch_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            rch_q   <= rch_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rch   = rch_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx at CLOCK=6.4 MHz, RATE=100 kbaud (DIV=4, 64 clks per bit).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rch;
    logic       valid;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fcnt = 0;
    int both_cnt = 0;
    int multi_cnt = 0;
    int rch_glitch = 0;
    logic       valid_prev = 1'b0;
    logic       ferr_prev = 1'b0;
    logic [7:0] rch_prev = 8'h00;
    int         vtimes[$];
    logic [7:0] vdata[$];

    rx #(
        .CLOCK (6_400_000),
        .RATE  (100_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .rch   (rch),
        .valid (valid),
        .ferr  (ferr),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse/stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            vtimes.push_back(cyc);
            vdata.push_back(rch);
        end
        if (ferr) fcnt++;
        if (valid && ferr) both_cnt++;
        if ((valid && valid_prev) || (ferr && ferr_prev)) multi_cnt++;
        if (reset && (rch != rch_prev) && !valid) rch_glitch++;
        valid_prev = valid;
        ferr_prev  = ferr;
        rch_prev   = rch;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All drives happen 1 time unit after a rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    function automatic logic [31:0] vdata_at(input int n);
        return (vdata.size() > n) ? {24'h0, vdata[n]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int vtime_at(input int n);
        return (vtimes.size() > n) ? vtimes[n] : -1;
    endfunction

    int v0;
    int f0;

    initial begin
        rxd   = 1'b1;
        reset = 1'b0;
        #1;
        chk("reset_rch",   {24'h0, rch}, 32'h00);
        chk("reset_valid", {31'h0, valid}, 0);
        chk("reset_ferr",  {31'h0, ferr}, 0);
        chk("reset_busy",  {31'h0, busy}, 0);
        wait_clks(5);
        reset = 1'b1;
        wait_clks(20);

        // Good frame 0x55
        v0 = vdata.size(); f0 = fcnt;
        send_frame(8'h55, 1'b1);
        wait_clks(10);
        chk("f55_valid_cnt", vdata.size() - v0, 1);
        chk("f55_ferr_cnt",  fcnt - f0, 0);
        chk("f55_rch",       {24'h0, rch}, 32'h55);
        chk("f55_busy",      {31'h0, busy}, 0);

        // 12-clk glitch: rejected at mid-start
        v0 = vdata.size(); f0 = fcnt;
        rxd = 1'b0;
        wait_clks(12);
        chk("glitch_busy_hi", {31'h0, busy}, 1);
        rxd = 1'b1;
        wait_clks(52);
        chk("glitch_busy_lo", {31'h0, busy}, 0);
        chk("glitch_valid",   vdata.size() - v0, 0);
        chk("glitch_ferr",    fcnt - f0, 0);

        // Framing error on 0xA3, then line held low (break)
        v0 = vdata.size(); f0 = fcnt;
        send_frame(8'hA3, 1'b0);
        wait_clks(200 - BIT_CLKS);
        chk("ferr_cnt",      fcnt - f0, 1);
        chk("ferr_valid",    vdata.size() - v0, 0);
        chk("ferr_rch_kept", {24'h0, rch}, 32'h55);
        chk("break_busy",    {31'h0, busy}, 0);
        rxd = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(8'h3C, 1'b1);
        wait_clks(10);
        chk("after_break_valid", vdata.size() - v0, 1);
        chk("after_break_rch",   {24'h0, rch}, 32'h3C);
        chk("after_break_ferr",  fcnt - f0, 1);

        // Reset during data bit 4 of 0x0F (line low in bit 4)
        v0 = vdata.size(); f0 = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b0;
        wait_clks(20);
        chk("pre_reset_busy", {31'h0, busy}, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy",  {31'h0, busy}, 0);
        chk("midrst_valid", {31'h0, valid}, 0);
        chk("midrst_ferr",  {31'h0, ferr}, 0);
        chk("midrst_rch",   {24'h0, rch}, 32'h00);
        wait_clks(10);
        reset = 1'b1;
        wait_clks(200);
        chk("lowrel_busy",  {31'h0, busy}, 0);
        chk("lowrel_valid", vdata.size() - v0, 0);
        chk("lowrel_ferr",  fcnt - f0, 0);
        rxd = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(8'h81, 1'b1);
        wait_clks(10);
        chk("rel_frame_valid", vdata.size() - v0, 1);
        chk("rel_frame_rch",   {24'h0, rch}, 32'h81);

        // Back-to-back 0x00 then 0xFF
        v0 = vdata.size(); f0 = fcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(20);
        chk("b2b_valid_cnt", vdata.size() - v0, 2);
        chk("b2b_first",     vdata_at(v0), 32'h00);
        chk("b2b_second",    vdata_at(v0 + 1), 32'hFF);
        chk("b2b_spacing",   vtime_at(v0 + 1) - vtime_at(v0), 640);
        chk("b2b_ferr",      fcnt - f0, 0);
        chk("b2b_rch",       {24'h0, rch}, 32'hFF);

        // Whole-run invariants
        chk("valid_ferr_overlap", both_cnt, 0);
        chk("pulse_width",        multi_cnt, 0);
        chk("rch_stability",      rch_glitch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
